// File: rtl/block_link_fifo.sv
// block_link_fifo: multi-channel 8x8 block FIFO between colour conversion and DCT.
// Stores up to DEPTH whole blocks (NUM_CH channels each) with a per-block channel
// enable mask and a 16-bit sequence tag. The head entry is presented show-ahead.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   flush          synchronous clear of stored blocks (tag counter kept)
//   in_valid/ready upstream block handshake; in_ready registered (count < DEPTH)
//   in_data        channel c word i at [(c*BLOCK_SIZE+i)*DATA_WIDTH +: DATA_WIDTH]
//   in_ch_en       channel enable mask, stored with the block
//   out_valid/ready downstream head-block handshake
//   out_data       head block, disabled channels read as zero
//   out_tag        sequence tag of head block
//   count          stored blocks, 0..DEPTH
module block_link_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_CH*BLOCK_SIZE*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]                      in_ch_en,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_CH*BLOCK_SIZE*DATA_WIDTH-1:0] out_data,
  output logic [15:0]                            out_tag,
  output logic [ADDR_W:0]                        count
);

  localparam int unsigned CH_W   = BLOCK_SIZE * DATA_WIDTH;
  localparam int unsigned BLK_W  = NUM_CH * CH_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned TAG_W  = 16;

  // Block storage; contents are don't-care after reset so no reset is applied.
  logic [BLK_W-1:0]  data_mem_q [DEPTH];
  logic [NUM_CH-1:0] en_mem_q   [DEPTH];
  logic [TAG_W-1:0]  tag_mem_q  [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TAG_W-1:0]  tag_cnt_q, tag_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic push_c;
  logic pop_c;
  logic wr_en_c;

  assign push_c  = in_valid && in_ready_q;
  assign pop_c   = out_valid_q && out_ready;
  // A flushed or reset cycle discards the incoming block.
  assign wr_en_c = push_c && !flush && !rst;

  // Next-state for pointers, occupancy, tag counter and handshake flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tag_cnt_d   = tag_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        tag_cnt_d = tag_cnt_q + TAG_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    in_ready_d  = (count_d != CNT_W'(DEPTH));
    out_valid_d = (count_d != CNT_W'(0));
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_cnt_q   <= tag_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage write on accepted push.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      data_mem_q[wr_ptr_q] <= in_data;
      en_mem_q[wr_ptr_q]   <= in_ch_en;
      tag_mem_q[wr_ptr_q]  <= tag_cnt_q;
    end
  end

  // Show-ahead head read with per-channel masking; zero while empty.
  logic [BLK_W-1:0]  head_data_c;
  logic [NUM_CH-1:0] head_en_c;

  assign head_data_c = data_mem_q[rd_ptr_q];
  assign head_en_c   = en_mem_q[rd_ptr_q];

  always_comb begin
    out_data = '0;
    if (out_valid_q) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (head_en_c[c]) begin
          out_data[c*CH_W +: CH_W] = head_data_c[c*CH_W +: CH_W];
        end
      end
    end
  end

  assign out_tag   = out_valid_q ? tag_mem_q[rd_ptr_q] : TAG_W'(0);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_block_link_fifo.sv
// Directed testbench for block_link_fifo: reset, latency, ordering, backpressure,
// channel masking, flush and tag wrap / mid-stream reset.
module tb_block_link_fifo;

  localparam int unsigned DW  = 32;
  localparam int unsigned BS  = 64;
  localparam int unsigned NC  = 3;
  localparam int unsigned DEP = 4;
  localparam int unsigned AW  = 2;
  localparam int unsigned CHW = BS * DW;
  localparam int unsigned TOT = NC * CHW;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [TOT-1:0] in_data;
  logic [NC-1:0]  in_ch_en;
  logic           out_valid;
  logic           out_ready;
  logic [TOT-1:0] out_data;
  logic [15:0]    out_tag;
  logic [AW:0]    count;

  int tests_run = 0;
  int tests_failed = 0;

  block_link_fifo #(
    .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .NUM_CH(NC), .DEPTH(DEP), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch_en(in_ch_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .count(count)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Block pattern: every word = base + channel*0x100 + word index.
  function automatic logic [TOT-1:0] make_block(input logic [31:0] base);
    logic [TOT-1:0] b;
    b = '0;
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < BS; i++)
        b[(c*BS+i)*DW +: DW] = base + 32'(c*256) + 32'(i);
    return b;
  endfunction

  // Index of first differing word, or -1.
  function automatic int first_diff(input logic [TOT-1:0] a, input logic [TOT-1:0] b);
    for (int w = 0; w < NC*BS; w++)
      if (a[w*DW +: DW] !== b[w*DW +: DW]) return w;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ch_en = '1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int d;
    do_reset();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
    tests_run++;
    if (out_tag !== 16'h0) begin tests_failed++; $display("FAIL reset_out_tag got %h want 0000", out_tag); end
    d = first_diff(out_data, '0);
    tests_run++;
    if (d >= 0) begin tests_failed++; $display("FAIL reset_out_data word %0d got %h want 0", d, out_data[d*DW +: DW]); end
  endtask

  task automatic test_latency();
    logic [TOT-1:0] blk;
    int d;
    do_reset();
    blk = make_block(32'h0001_0000);
    in_data = blk; in_valid = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_pre_valid got %b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_valid got %b want 1", out_valid); end
    tests_run++;
    if (out_tag !== 16'h0) begin tests_failed++; $display("FAIL lat_tag got %h want 0000", out_tag); end
    d = first_diff(out_data, blk);
    tests_run++;
    if (d >= 0) begin tests_failed++; $display("FAIL lat_data word %0d got %h want %h", d, out_data[d*DW +: DW], blk[d*DW +: DW]); end
    tests_run++;
    if (count !== 3'd1) begin tests_failed++; $display("FAIL lat_count got %0d want 1", count); end
  endtask

  task automatic test_ordering();
    logic [TOT-1:0] blk;
    int d;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      in_data = make_block(32'h0001_0000 * 32'(b+1)); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd4) begin tests_failed++; $display("FAIL ord_full_count got %0d want 4", count); end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL ord_full_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      blk = make_block(32'h0001_0000 * 32'(b+1));
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL ord_valid blk %0d got %b want 1", b, out_valid); end
      tests_run++;
      if (out_tag !== 16'(b)) begin tests_failed++; $display("FAIL ord_tag blk %0d got %h want %h", b, out_tag, 16'(b)); end
      d = first_diff(out_data, blk);
      tests_run++;
      if (d >= 0) begin tests_failed++; $display("FAIL ord_data blk %0d word %0d got %h want %h", b, d, out_data[d*DW +: DW], blk[d*DW +: DW]); end
      step();
    end
    out_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("FAIL ord_empty_count got %0d want 0", count); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL ord_empty_ready got %b want 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ord_empty_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [TOT-1:0] head;
    int d;
    do_reset();
    head = make_block(32'hA000_0000);
    in_data = head; in_valid = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i < 3) in_data = make_block(32'hA000_0000 + 32'h0100_0000 * 32'(i+1));
      in_valid = 1'b1;
      step();
      d = first_diff(out_data, head);
      tests_run++;
      if (d >= 0 || out_tag !== 16'h0) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d tag %h want 0000 diff_word %0d", i, out_tag, d);
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd4) begin tests_failed++; $display("FAIL bp_count got %0d want 4", count); end
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tests_run++;
      if (out_tag !== 16'(b) || out_data[DW-1:0] !== 32'hA000_0000 + 32'h0100_0000 * 32'(b)) begin
        tests_failed++;
        $display("FAIL bp_drain blk %0d tag %h word0 %h", b, out_tag, out_data[DW-1:0]);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_channel_mask();
    logic [TOT-1:0] blk;
    logic [TOT-1:0] exp_v;
    int d;
    do_reset();
    blk = '0;
    for (int i = 0; i < BS; i++) begin
      blk[(0*BS+i)*DW +: DW] = 32'h1000_0000 + 32'(i);
      blk[(1*BS+i)*DW +: DW] = 32'hDEAD_BEEF;
      blk[(2*BS+i)*DW +: DW] = 32'h3000_0000 + 32'(i);
    end
    exp_v = blk;
    exp_v[CHW +: CHW] = '0;
    in_data = blk; in_ch_en = 3'b101; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_ch_en = 3'b111;
    d = first_diff(out_data, exp_v);
    tests_run++;
    if (d >= 0) begin tests_failed++; $display("FAIL mask_data word %0d got %h want %h", d, out_data[d*DW +: DW], exp_v[d*DW +: DW]); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int b = 0; b < 3; b++) begin
      in_data = make_block(32'h0005_0000 * 32'(b+1)); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_count got %0d want 3", count); end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_data = make_block(32'h0BAD_0000);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0) begin tests_failed++; $display("FAIL flush_count got %0d want 0", count); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid got %b want 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready got %b want 1", in_ready); end
    in_data = make_block(32'h0007_0000); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_tag !== 16'd3) begin tests_failed++; $display("FAIL flush_next_tag got %h want 0003", out_tag); end
  endtask

  task automatic test_tag_wrap();
    int bad_count;
    logic [15:0] exp_tag [3];
    exp_tag[0] = 16'hFFFE; exp_tag[1] = 16'hFFFF; exp_tag[2] = 16'h0000;
    do_reset();
    in_data = make_block(32'h0);
    in_valid = 1'b1;
    step();
    out_ready = 1'b1;
    bad_count = 0;
    for (int k = 0; k < 65534; k++) begin
      step();
      if (count !== 3'd1 || out_valid !== 1'b1) bad_count++;
    end
    tests_run++;
    if (bad_count != 0) begin tests_failed++; $display("FAIL wrap_count_steady got %0d bad cycles want 0", bad_count); end
    for (int j = 0; j < 3; j++) begin
      tests_run++;
      if (out_tag !== exp_tag[j]) begin tests_failed++; $display("FAIL wrap_tag %0d got %h want %h", j, out_tag, exp_tag[j]); end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_rst count %0d valid %b want 0 0", count, out_valid); end
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_tag !== 16'h0 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_rst_tag got %h valid %b want 0000 1", out_tag, out_valid); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ch_en = '1;
    test_reset();
    test_latency();
    test_ordering();
    test_backpressure();
    test_channel_mask();
    test_flush();
    test_tag_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
